instr_fetch_unit: RTL

- Producer side of the control unit's Op/funct3/funct7 interface.
- Owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers one instruction and presents it with its PC and pre-sliced decode fields to the decode/control stage under a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards stale in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-outstanding instruction fetcher feeding decode with
//            Instr/PC and pre-sliced Op/funct3/funct7 fields.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      Op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            misalign_err
);

    localparam logic [1:0]      C_ST_ISSUE = 2'd0;
    localparam logic [1:0]      C_ST_WAIT  = 2'd1;
    localparam logic [1:0]      C_ST_HOLD  = 2'd2;
    localparam logic [1:0]      C_ST_HALT  = 2'd3;
    localparam logic [XLEN-1:0] C_WORD     = XLEN'(4);

    logic [1:0]      state_q,    state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q,   req_pc_d;
    logic            drop_q,     drop_d;
    logic [31:0]     instr_q,    instr_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic            misalign_q, misalign_d;
    logic            w_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= C_ST_ISSUE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= 32'h0;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);

    // A redirect outranks every other event; drop_q marks the one
    // outstanding response as stale so it never reaches the buffer.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        case (state_q)
            C_ST_ISSUE: begin
                if (redirect && w_misaligned) begin
                    misalign_d = 1'b1;
                    drop_d     = 1'b0;
                    state_d    = C_ST_HALT;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_req_ready) begin
                        req_pc_d = fetch_pc_q;
                        drop_d   = 1'b1;
                        state_d  = C_ST_WAIT;
                    end
                end else if (imem_req_ready) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = C_ST_WAIT;
                end
            end
            C_ST_WAIT: begin
                if (redirect && w_misaligned) begin
                    misalign_d = 1'b1;
                    drop_d     = 1'b0;
                    state_d    = C_ST_HALT;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = C_ST_ISSUE;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = C_ST_ISSUE;
                    end else begin
                        instr_d    = imem_rsp_data;
                        pc_d       = req_pc_q;
                        fetch_pc_d = req_pc_q + C_WORD;
                        state_d    = C_ST_HOLD;
                    end
                end
            end
            C_ST_HOLD: begin
                if (redirect && w_misaligned) begin
                    misalign_d = 1'b1;
                    state_d    = C_ST_HALT;
                end else if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = C_ST_ISSUE;
                end else if (instr_ready) begin
                    state_d = C_ST_ISSUE;
                end
            end
            default: begin
                state_d = C_ST_HALT;
            end
        endcase
    end

    // Request valid is gated by rst so nothing is requested during reset.
    always_comb begin
        imem_req_valid = rst && (state_q == C_ST_ISSUE);
        imem_req_addr  = fetch_pc_q;
        instr_valid    = (state_q == C_ST_HOLD);
        Instr          = instr_q;
        PC             = pc_q;
        PCPlus4        = pc_q + C_WORD;
        Op             = instr_q[6:0];
        funct3         = instr_q[14:12];
        funct7         = instr_q[31:25];
        misalign_err   = misalign_q;
    end

endmodule
`default_nettype wire
